// File: rtl/asym_fifo_pkg.sv
// rtl/asym_fifo_pkg.sv - shared constants and helpers for the wide-in / narrow-out FIFO
package asym_fifo_pkg;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int WIDTHA_DEF     = 16;
    localparam int WIDTHB_DEF     = 4;
    localparam int ADDRWIDTHA_DEF = 8;

    // Narrow words per wide word and its log2.
    localparam int RATIO_DEF  = WIDTHA_DEF / WIDTHB_DEF;
    localparam int LOG2R_DEF  = clog2(RATIO_DEF);

    // Pointer widths: wide-unit write pointer and narrow-unit read pointer, each with a wrap bit.
    localparam int WPTR_W_DEF = ADDRWIDTHA_DEF + 1;
    localparam int RPTR_W_DEF = ADDRWIDTHA_DEF + LOG2R_DEF + 1;
    localparam int NDEPTH_DEF = RATIO_DEF << ADDRWIDTHA_DEF;

endpackage

// File: rtl/wide_narrow_ram.sv
// rtl/wide_narrow_ram.sv - wide write / narrow registered read RAM
module wide_narrow_ram #(
    parameter int WIDTHA     = 16,
    parameter int WIDTHB     = 4,
    parameter int ADDRWIDTHA = 8,
    parameter int LOG2R      = 2
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [ADDRWIDTHA-1:0]       waddr,
    input  logic [WIDTHA-1:0]           wdata,
    input  logic                        rd_en,
    input  logic [ADDRWIDTHA+LOG2R-1:0] raddr,
    output logic [WIDTHB-1:0]           rdata
);

    localparam int RATIO  = WIDTHA / WIDTHB;
    localparam int NDEPTH = RATIO << ADDRWIDTHA;

    logic [WIDTHB-1:0] mem [NDEPTH];
    logic [WIDTHB-1:0] rdata_q;

    // Wide word lands in slots {waddr, i}, least significant slice at i = 0; read is registered.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < RATIO; i++) begin
                mem[{waddr, LOG2R'(i)}] <= wdata[i*WIDTHB +: WIDTHB];
            end
        end
        if (rd_en) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/asym_fifo_ctrl.sv
// rtl/asym_fifo_ctrl.sv - wide-write, narrow-read FIFO controller with 2-entry output stage
module asym_fifo_ctrl
    import asym_fifo_pkg::*;
#(
    parameter int WIDTHA     = WIDTHA_DEF,
    parameter int WIDTHB     = WIDTHB_DEF,
    parameter int ADDRWIDTHA = ADDRWIDTHA_DEF
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         flush,
    input  logic                                         s_valid,
    output logic                                         s_ready,
    input  logic [WIDTHA-1:0]                            s_data,
    output logic                                         m_valid,
    input  logic                                         m_ready,
    output logic [WIDTHB-1:0]                            m_data,
    output logic [ADDRWIDTHA+clog2(WIDTHA/WIDTHB):0]     level
);

    localparam int RATIO = WIDTHA / WIDTHB;
    localparam int LOG2R = clog2(RATIO);
    localparam int WPW   = ADDRWIDTHA + 1;
    localparam int RPW   = ADDRWIDTHA + LOG2R + 1;
    localparam logic [RPW-1:0] NDEPTH  = RPW'(RATIO << ADDRWIDTHA);
    localparam logic [RPW-1:0] RATIO_L = RPW'(RATIO);

    logic [WPW-1:0]    wptr_q, wptr_d;
    logic [RPW-1:0]    rptr_q, rptr_d;
    logic [WIDTHB-1:0] head_q, head_d, skid_q, skid_d;
    logic              head_v_q, head_v_d, skid_v_q, skid_v_d;
    logic              pend_q, pend_d;

    logic [RPW-1:0]    occ;
    logic [1:0]        in_use, in_use_next;
    logic              wr, pop, issue;
    logic [RPW-2:0]    rd_addr;
    logic [WIDTHB-1:0] rdata;

    // Occupancy counts everything not yet consumed, including the output stage.
    assign occ         = {wptr_q, {LOG2R{1'b0}}} - rptr_q;
    assign s_ready     = !rst && !flush && ((NDEPTH - occ) >= RATIO_L);
    assign wr          = s_valid && s_ready;
    assign pop         = head_v_q && m_ready;
    // Slots held by the stage or by a read in flight; the pop this cycle frees one so full rate is sustained.
    assign in_use      = 2'({1'b0, head_v_q} + {1'b0, skid_v_q} + {1'b0, pend_q});
    assign in_use_next = in_use - {1'b0, pop};
    assign issue       = !flush && (occ > RPW'(in_use)) && (in_use_next < 2'd2);
    assign rd_addr     = rptr_q[RPW-2:0] + (RPW-1)'(in_use);

    assign m_valid = head_v_q;
    assign m_data  = head_q;
    assign level   = occ;

    wide_narrow_ram #(
        .WIDTHA     (WIDTHA),
        .WIDTHB     (WIDTHB),
        .ADDRWIDTHA (ADDRWIDTHA),
        .LOG2R      (LOG2R)
    ) u_ram (
        .clk   (clk),
        .wr_en (wr),
        .waddr (wptr_q[ADDRWIDTHA-1:0]),
        .wdata (s_data),
        .rd_en (issue),
        .raddr (rd_addr),
        .rdata (rdata)
    );

    // Next-state: pointer advance, head/skid shuffle on pop and RAM return, flush clears everything.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        head_d   = head_q;
        head_v_d = head_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        pend_d   = issue;

        if (wr) begin
            wptr_d = wptr_q + WPW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + RPW'(1);
        end

        if (pop) begin
            if (skid_v_q) begin
                head_d   = skid_q;
                head_v_d = 1'b1;
                skid_v_d = pend_q;
                if (pend_q) begin
                    skid_d = rdata;
                end
            end else begin
                head_v_d = pend_q;
                if (pend_q) begin
                    head_d = rdata;
                end
            end
        end else if (pend_q) begin
            if (head_v_q) begin
                skid_d   = rdata;
                skid_v_d = 1'b1;
            end else begin
                head_d   = rdata;
                head_v_d = 1'b1;
            end
        end

        if (flush) begin
            wptr_d   = '0;
            rptr_d   = '0;
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
            pend_d   = 1'b0;
        end
    end

    // State register with synchronous reset; output data also returns to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            head_q   <= '0;
            head_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            head_q   <= head_d;
            head_v_q <= head_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// tb/tb_asym_fifo_ctrl.sv - randomized and directed bench with a nibble-queue reference model
module tb_asym_fifo_ctrl;
    import asym_fifo_pkg::*;

    localparam int WA = WIDTHA_DEF;
    localparam int WB = WIDTHB_DEF;
    localparam int AW = ADDRWIDTHA_DEF;
    localparam int LW = RPTR_W_DEF;
    localparam int ND = NDEPTH_DEF;
    localparam int R  = RATIO_DEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [WA-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [WB-1:0] m_data;
    logic [LW-1:0] level;

    int n_pass = 0;
    int n_total = 0;
    int unsigned mq[$];
    int gap = 0;
    logic [3:0] got[$];
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    asym_fifo_ctrl #(.WIDTHA(WA), .WIDTHB(WB), .ADDRWIDTHA(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .level   (level)
    );

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: queue of narrow words; checked every cycle, then updated with the coming edge's transfers.
    always @(negedge clk) begin
        bit exp_rdy;
        exp_rdy = !rst && !flush && ((ND - mq.size()) >= R);
        chk("level", level == LW'(mq.size()), level, mq.size());
        chk("s_ready", s_ready == exp_rdy, s_ready, exp_rdy);
        if (m_valid) begin
            chk("m_valid_has_data", mq.size() != 0, mq.size(), 1);
            if (mq.size() != 0) chk("m_data", m_data == mq[0][3:0], m_data, mq[0]);
        end
        if (rst || flush) gap = 0;
        else if (mq.size() > 0 && !m_valid) begin
            gap++;
            chk("m_valid_gap", gap <= 2, gap, 2);
        end else gap = 0;

        if (rst || flush) mq.delete();
        else begin
            if (m_valid && m_ready && mq.size() > 0) void'(mq.pop_front());
            if (s_valid && s_ready)
                for (int i = 0; i < R; i++) mq.push_back(int'(s_data[i*WB +: WB]));
        end
    end

    task automatic push_word(input logic [WA-1:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("push_timeout", 1'b0, n, 3000);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic collect(input int n, input bit toggle);
        got.delete();
        for (int k = 0; k < 200 && got.size() < n; k++) begin
            m_ready = toggle ? pat[k % 4] : 1'b1;
            @(negedge clk);
            if (m_valid && m_ready) got.push_back(m_data);
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        chk("collect_count", got.size() == n, got.size(), n);
    endtask

    task automatic check_got(input string name, input logic [15:0] exp4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk(name, got[i] == exp4[15-4*i -: 4], got[i], exp4[15-4*i -: 4]);
    endtask

    initial begin
        int ev[7] = '{0, 0, 1, 1, 1, 1, 0};
        int ed[7] = '{0, 0, 'hD, 'hC, 'hB, 'hA, 0};
        int cnt;
        int written;

        // Reset and release
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_s_ready", s_ready == 1'b0, s_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", m_valid == 1'b0, m_valid, 0);
        chk("rst_level", level == '0, level, 0);
        chk("rst_m_data", m_data == '0, m_data, 0);
        chk("post_rst_s_ready", s_ready == 1'b1, s_ready, 1);
        @(posedge clk); #1;

        // Single word order and latency
        m_ready = 1'b1;
        push_word(16'hABCD);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("lat_m_valid", m_valid == ev[k][0], m_valid, ev[k]);
            if (ev[k] != 0) chk("order_data", m_data == ed[k][3:0], m_data, ed[k]);
        end
        @(posedge clk); #1;
        m_ready = 1'b0;

        // Backpressure 1,0,0,1
        push_word(16'h1234);
        collect(4, 1'b1);
        check_got("bp_data", 16'h4321);

        // Fill to full
        for (int i = 0; i < 256; i++) push_word(WA'($urandom));
        @(negedge clk);
        chk("full_s_ready", s_ready == 1'b0, s_ready, 0);
        chk("full_level", level == LW'(1024), level, 1024);
        chk("model_full", mq.size() == 1024, mq.size(), 1024);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            m_ready = 1'b1;
            @(negedge clk);
            chk("full_m_valid", m_valid == 1'b1, m_valid, 1);
            @(posedge clk); #1;
            m_ready = 1'b0;
            @(negedge clk);
            chk("drain_s_ready", s_ready == (i == 3), s_ready, (i == 3));
            chk("drain_level", level == LW'(1023 - i), level, 1023 - i);
            @(posedge clk); #1;
        end

        // Full-rate drain of the remaining 1020 words
        m_ready = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (m_valid && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        chk("throughput_run", cnt == 1020, cnt, 1020);
        @(posedge clk); #1;
        m_ready = 1'b0;

        // Flush with 10 words stored, concurrent handshakes offered
        for (int i = 0; i < 10; i++) push_word(WA'($urandom));
        @(negedge clk);
        chk("pre_flush_m_valid", m_valid == 1'b1, m_valid, 1);
        @(posedge clk); #1;
        flush = 1'b1;
        s_valid = 1'b1;
        s_data = 16'hFFFF;
        m_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        chk("flush_m_valid", m_valid == 1'b0, m_valid, 0);
        chk("flush_level", level == '0, level, 0);
        chk("flush_s_ready", s_ready == 1'b1, s_ready, 1);
        @(posedge clk); #1;
        push_word(16'h00F0);
        collect(4, 1'b0);
        check_got("flush_data", 16'h0F00);

        // Random stream across pointer wraps
        written = 0;
        for (int c = 0; c < 30000 && written < 1000; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = WA'($urandom);
            m_ready = $urandom_range(0, 1) != 0;
            @(negedge clk);
            if (s_valid && s_ready) written++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("wrap_written", written == 1000, written, 1000);
        m_ready = 1'b1;
        for (int c = 0; c < 5000 && mq.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk("wrap_drained", mq.size() == 0, mq.size(), 0);
        m_ready = 1'b0;

        // Reset mid-stream
        for (int c = 0; c < 40; c++) begin
            s_valid = 1'b1;
            s_data  = WA'($urandom);
            m_ready = $urandom_range(0, 1) != 0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_ready", s_ready == 1'b0, s_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", m_valid == 1'b0, m_valid, 0);
        chk("midrst_level", level == '0, level, 0);
        chk("midrst_m_data", m_data == '0, m_data, 0);
        chk("midrst_s_ready_rel", s_ready == 1'b1, s_ready, 1);
        @(posedge clk); #1;
        push_word(16'h5A3C);
        collect(4, 1'b0);
        check_got("midrst_data", 16'hC3A5);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/asym_fifo_ctrl.md
ASYM_FIFO_CTRL -- requirements
Module: asym_fifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTHA, default 16: write word width in bits.
REQ-002 SHALL have parameter WIDTHB, default 4: read word width in bits; WIDTHA = RATIO*WIDTHB, RATIO a power of two, at least 2.
REQ-003 SHALL have parameter ADDRWIDTHA, default 8: wide-side address width; wide depth 2**ADDRWIDTHA, narrow depth RATIO*2**ADDRWIDTHA.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge; reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port flush, input, 1: synchronous discard of all stored and in-flight data.
REQ-007 SHALL have port s_valid, input, 1: write word offered.
REQ-008 SHALL have port s_ready, output, 1: a write word can be accepted.
REQ-009 SHALL have port s_data, input, WIDTHA: write word.
REQ-010 SHALL have port m_valid, output, 1: a narrow word is presented.
REQ-011 SHALL have port m_ready, input, 1: consumer accepts the narrow word.
REQ-012 SHALL have port m_data, output, WIDTHB: narrow read word.
REQ-013 SHALL have port level, output, ADDRWIDTHA+log2(RATIO)+1: narrow words stored, including the output stage.

Function
REQ-014 SHALL transfer a write word when s_valid and s_ready are both high at a clk edge, and a read word when m_valid and m_ready are both high.
REQ-015 SHALL unpack each write word least significant slice first: slice i is s_data[(i+1)*WIDTHB-1 -: WIDTHB], i = 0..RATIO-1.
REQ-016 SHALL keep a write pointer in wide units and a read pointer in narrow units, each with one extra wrap bit; both pointers SHALL wrap modulo 2x depth.
REQ-017 SHALL set occupancy to {wptr,log2(RATIO) zeros} - rptr, computed modulo 2x narrow depth.
REQ-018 SHALL drive s_ready = !rst && !flush && (narrow depth - occupancy) >= RATIO; a partially drained wide slot SHALL block writing.
REQ-019 SHALL read RAM with 1-cycle latency and feed a 2-entry output stage (head register plus skid); it SHALL issue a read when occupancy minus (stage entries plus in-flight reads) > 0 and stage entries plus in-flight reads < 2.
REQ-020 SHALL give m_valid = head entry valid; m_data SHALL hold steady while m_valid && !m_ready.
REQ-021 SHALL sustain a throughput of 1 narrow word per cycle while data is available and m_ready is high.
REQ-022 SHALL have latency from the first write handshake into an empty FIFO to m_valid of 2 cycles (read issued edge+1, m_valid at edge+2).
REQ-023 SHALL on a simultaneous write and read apply both; occupancy changes by RATIO-1.
REQ-024 SHALL never address a RAM location that is being written, because the full rule guarantees it.
REQ-025 SHALL on flush zero both pointers, invalidate the stage, and discard in-flight reads at the next edge; flush SHALL override a concurrent handshake.
REQ-026 SHALL drive level equal to occupancy.

Reset
REQ-027 SHALL, when rst is sampled high, set pointers 0, stage empty, m_valid 0, level 0, and m_data 0.
REQ-028 SHALL hold s_ready 0 while rst is high, and 1 in the first cycle after release.
REQ-029 SHALL treat reset mid-transfer as a flush: all data is lost and no stale m_valid appears.

Structure
REQ-030 SHALL place the RATIO and log2 constants, the pointer-width localparams, and the clog2 function in package asym_fifo_pkg.
REQ-031 SHALL instantiate storage as one sub-module, wide_narrow_ram: single clock, WIDTHA write port, WIDTHB registered read port with enable, and write addressing {addrA, i}.
REQ-032 SHALL contain no other storage than that RAM and the 2-entry output stage.

Verification
REQ-033 SHALL cover this single-word order scenario: write 0xABCD with m_ready=1 -> m_data 0xD,0xC,0xB,0xA on consecutive cycles starting 2 cycles after the handshake.
REQ-034 SHALL cover this fill-to-full scenario: with m_ready=0, write 256 words -> s_ready falls after the 256th, level=1024; after reading 3 nibbles s_ready stays 0; the 4th read sets s_ready 1.
REQ-035 SHALL cover this backpressure scenario: write 0x1234 and toggle m_ready 1,0,0,1,... -> m_data holds during stalls; sequence 4,3,2,1 with no loss or duplication.
REQ-036 SHALL cover this wrap scenario: stream 1000 random words with random m_ready (50%) -> the output equals the scoreboard nibble stream across both pointer wraps.
REQ-037 SHALL cover this flush scenario: assert flush with 10 words stored and m_valid high -> the next cycle m_valid=0, level=0, s_ready=1, and a subsequent write 0x00F0 yields 0x0,0xF,0x0,0x0.
REQ-038 SHALL cover this reset mid-stream scenario: assert rst for 1 cycle during a stream -> all outputs reach reset values and the first post-reset word reads back correctly.
